// File: rtl/i2c_arb_pkg.sv
// Shared types and helpers for the I2C bus arbiter.
//   arb_state_t : arbiter FSM states
//   ADDR_W      : I2C slave address width
//   DATA_W      : I2C data byte width
//   MAX_REQ     : largest supported requester count
//   onehot()    : index to one-hot vector (MAX_REQ wide, caller truncates)
package i2c_arb_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : requests eligible this cycle
//   last_i   : index of the most recent owner
//   valid_o  : at least one eligible request
//   winner_o : first requesting index after last_i, wrapping
module i2c_arb_rr_pick #(
  parameter int C_NUM_REQ = 2,
  parameter int IW        = $clog2(C_NUM_REQ)
) (
  input  logic [C_NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]        last_i,
  output logic                 valid_o,
  output logic [IW-1:0]        winner_o
);

  logic [IW-1:0] cand;

  // Scan last+1, last+2, ... last+N; the first hit wins.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int k = 1; k <= C_NUM_REQ; k++) begin
      cand = IW'((int'(last_i) + k) % C_NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master core among C_NUM_REQ requesters.
// Round-robin grant taken only while the master is idle, held for the
// whole transaction; a watchdog force-releases a hung owner.
//   clk, rst                  : clock, synchronous active-high reset
//   req_* (in)                : per-requester master-side request signals
//   req_rdata/act/err/next    : per-requester response views
//   gnt                       : registered one-hot grant
//   timeout_irq               : 1-cycle pulse on forced release
//   en/addr/write/wdata/multibyte_n (out), rdata/act/err/next (in) : master
//
// state | meaning
// IDLE  | no owner; grant when master idle and an unblocked request exists
// GRANT | owner's request muxed to the master; watchdog running
// DRAIN | master inputs forced to 0; wait for act to clear
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int C_NUM_REQ = 2,
  parameter int C_TIMEOUT = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_NUM_REQ-1:0]          req_en,
  input  logic [ADDR_W*C_NUM_REQ-1:0]   req_addr,
  input  logic [C_NUM_REQ-1:0]          req_write,
  input  logic [DATA_W*C_NUM_REQ-1:0]   req_wdata,
  input  logic [C_NUM_REQ-1:0]          req_multibyte_n,
  output logic [DATA_W-1:0]             req_rdata,
  output logic [C_NUM_REQ-1:0]          req_act,
  output logic [C_NUM_REQ-1:0]          req_err,
  output logic [C_NUM_REQ-1:0]          req_next,
  output logic [C_NUM_REQ-1:0]          gnt,
  output logic                          timeout_irq,
  output logic                          en,
  output logic [ADDR_W-1:0]             addr,
  output logic                          write,
  output logic [DATA_W-1:0]             wdata,
  output logic                          multibyte_n,
  input  logic [DATA_W-1:0]             rdata,
  input  logic                          act,
  input  logic                          err,
  input  logic                          next
);

  localparam int IW = $clog2(C_NUM_REQ);
  localparam int WW = $clog2(C_TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(C_TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(C_TIMEOUT);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic [IW-1:0]        last_q, last_d;
  logic [C_NUM_REQ-1:0] gnt_q, gnt_d;
  logic [C_NUM_REQ-1:0] blocked_q, blocked_d;
  logic [WW-1:0]        wdog_q, wdog_d;

  logic                 pick_valid;
  logic [IW-1:0]        pick_idx;
  logic                 owner_en;
  logic                 timeout;
  logic                 drive;

  i2c_arb_rr_pick #(
    .C_NUM_REQ (C_NUM_REQ),
    .IW        (IW)
  ) u_pick (
    .req_i    (req_en & ~blocked_q),
    .last_i   (last_q),
    .valid_o  (pick_valid),
    .winner_o (pick_idx)
  );

  assign owner_en = req_en[owner_q];
  // An en drop in the deadline cycle is a normal release, not a timeout.
  assign timeout  = (state_q == GRANT) && owner_en && (wdog_q == WDOG_LAST) && !rst;
  // Reset drops the master request at once, before the state register clears.
  assign drive    = (state_q == GRANT) && !rst;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    wdog_d    = wdog_q;
    // A block lasts only until the requester lets go of en.
    blocked_d = (blocked_q & req_en) |
                (timeout ? C_NUM_REQ'(onehot(3'(owner_q))) : '0);
    unique case (state_q)
      IDLE: begin
        if (!act && pick_valid) begin
          owner_d = pick_idx;
          gnt_d   = C_NUM_REQ'(onehot(3'(pick_idx)));
          wdog_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
        if (!owner_en || timeout) state_d = DRAIN;
      end
      DRAIN: begin
        if (!act) begin
          last_d  = owner_q;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= IW'(C_NUM_REQ - 1);
      gnt_q     <= '0;
      wdog_q    <= '0;
      blocked_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      wdog_q    <= wdog_d;
      blocked_q <= blocked_d;
    end
  end

  assign gnt         = gnt_q;
  assign timeout_irq = timeout;

  assign en          = drive & owner_en;
  assign write       = drive & req_write[owner_q];
  assign multibyte_n = drive & req_multibyte_n[owner_q];
  assign addr        = drive ? req_addr[int'(owner_q)*ADDR_W +: ADDR_W] : '0;
  assign wdata       = drive ? req_wdata[int'(owner_q)*DATA_W +: DATA_W] : '0;

  assign req_rdata   = rdata;

  // Non-owners see the bus as busy for the whole ownership window.
  always_comb begin
    req_act  = '0;
    req_err  = '0;
    req_next = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (state_q == IDLE) begin
        req_act[i] = act;
      end else if (owner_q == IW'(i)) begin
        req_act[i]  = act;
        req_err[i]  = err | timeout;
        req_next[i] = next;
      end else begin
        req_act[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;

  localparam int N = 3;
  localparam int T = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_en, req_write, req_multibyte_n;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic [7:0]     req_rdata;
  logic [N-1:0]   req_act, req_err, req_next, gnt;
  logic           timeout_irq, en, write, multibyte_n;
  logic [6:0]     addr;
  logic [7:0]     wdata, rdata;
  logic           act, err, next;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus and for how many grant cycles.
  int       m_phase;   // 0 free, 1 owner driving, 2 owner released / waiting for act
  int       m_owner;
  int       m_last;
  int       m_age;     // grant cycles elapsed including the current one
  bit [N-1:0] m_blk;

  i2c_bus_arbiter #(.C_NUM_REQ(N), .C_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_en(req_en), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_multibyte_n(req_multibyte_n),
    .req_rdata(req_rdata), .req_act(req_act), .req_err(req_err),
    .req_next(req_next), .gnt(gnt), .timeout_irq(timeout_irq),
    .en(en), .addr(addr), .write(write), .wdata(wdata),
    .multibyte_n(multibyte_n), .rdata(rdata), .act(act), .err(err), .next(next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_age   = 0;
    m_blk   = '0;
  endfunction

  function automatic bit model_timeout();
    return (m_phase == 1) && !rst && req_en[m_owner] && (m_age == T);
  endfunction

  task automatic compare_model();
    logic [N-1:0] e_act, e_err, e_next, e_gnt;
    bit drv, tmo;
    drv = (m_phase == 1) && !rst;
    tmo = model_timeout();
    e_gnt = (m_phase != 0) ? N'(1 << m_owner) : '0;
    for (int i = 0; i < N; i++) begin
      if (m_phase == 0)      begin e_act[i] = act;  e_err[i] = 1'b0;      e_next[i] = 1'b0; end
      else if (i == m_owner) begin e_act[i] = act;  e_err[i] = err | tmo; e_next[i] = next; end
      else                   begin e_act[i] = 1'b1; e_err[i] = 1'b0;      e_next[i] = 1'b0; end
    end
    chk("m_gnt",   gnt,         e_gnt);
    chk("m_irq",   timeout_irq, tmo);
    chk("m_en",    en,          drv & req_en[m_owner]);
    chk("m_write", write,       drv & req_write[m_owner]);
    chk("m_mbn",   multibyte_n, drv & req_multibyte_n[m_owner]);
    chk("m_addr",  addr,        drv ? req_addr[7*m_owner +: 7] : 7'd0);
    chk("m_wdata", wdata,       drv ? req_wdata[8*m_owner +: 8] : 8'd0);
    chk("m_rdata", req_rdata,   rdata);
    chk("m_ract",  req_act,     e_act);
    chk("m_rerr",  req_err,     e_err);
    chk("m_rnext", req_next,    e_next);
  endtask

  task automatic model_edge();
    bit tmo;
    int pick;
    if (rst) begin
      model_reset();
      return;
    end
    tmo  = model_timeout();
    pick = -1;
    if (m_phase == 0 && !act)
      for (int k = 1; k <= N; k++)
        if (pick < 0 && req_en[(m_last + k) % N] && !m_blk[(m_last + k) % N])
          pick = (m_last + k) % N;
    for (int i = 0; i < N; i++) if (!req_en[i]) m_blk[i] = 1'b0;
    if (tmo) m_blk[m_owner] = 1'b1;
    case (m_phase)
      0: if (pick >= 0) begin m_owner = pick; m_age = 1; m_phase = 1; end
      1: begin
        if (!req_en[m_owner] || tmo) m_phase = 2;
        else m_age++;
      end
      default: if (!act) begin m_last = m_owner; m_phase = 0; end
    endcase
  endtask

  task automatic step();
    #1;
    compare_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_en = '0; act = 1'b0; err = 1'b0; next = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_en = '0; req_write = '0; req_multibyte_n = '0;
    req_addr = '0; req_wdata = '0; rdata = '0; act = 1'b0; err = 1'b0; next = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_en",  en, 1'b0);
    chk("rst_irq", timeout_irq, 1'b0);
    step();

    // 1: single request
    rst = 1'b0;
    req_en = 3'b001; req_addr[6:0] = 7'h2A; req_wdata[7:0] = 8'h5C; req_write = 3'b001;
    #1 chk("t1_latency", gnt, 3'b000);
    step();
    chk("t1_gnt",   gnt, 3'b001);
    chk("t1_en",    en, 1'b1);
    chk("t1_addr",  addr, 7'h2A);
    chk("t1_wdata", wdata, 8'h5C);
    act = 1'b1;
    repeat (3) step();
    req_en = 3'b000;
    #1 chk("t1_en_drop", en, 1'b0);
    step();
    act = 1'b0;
    step();
    chk("t1_release", gnt, 3'b000);

    // 2: contention, order 0,1,0,1
    do_reset();
    req_en = 3'b011;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 4 && gnt == '0; w++) step();
      chk("t2_order", gnt, (k % 2 == 0) ? 3'b001 : 3'b010);
      chk("t2_nonowner_act", req_act[(k % 2 == 0) ? 1 : 0], 1'b1);
      req_en[k % 2] = 1'b0;
      step();
      req_en = 3'b011;
      step();
    end

    // 3: busy master blocks the grant
    do_reset();
    act = 1'b1; req_en = 3'b001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_busy_nognt", gnt, 3'b000);
    end
    act = 1'b0;
    step();
    chk("t3_gnt", gnt, 3'b001);

    // 4: timeout on owner 0
    do_reset();
    req_en = 3'b011;
    step();
    for (int c = 1; c < T; c++) begin
      chk("t4_early_irq", timeout_irq, 1'b0);
      step();
    end
    chk("t4_irq",  timeout_irq, 1'b1);
    chk("t4_err",  req_err, 3'b001);
    step();
    chk("t4_drain_en",  en, 1'b0);
    chk("t4_irq_pulse", timeout_irq, 1'b0);
    step();
    step();
    chk("t4_pass_to_1", gnt, 3'b010);
    req_en = 3'b001;
    step();
    step();
    step();
    chk("t4_blocked", gnt, 3'b000);
    req_en = 3'b000;
    step();
    req_en = 3'b001;
    step();
    chk("t4_unblocked", gnt, 3'b001);

    // 5: en drop exactly at the deadline
    do_reset();
    req_en = 3'b001;
    step();
    repeat (T - 1) step();
    req_en = 3'b000;
    #1;
    chk("t5_no_irq", timeout_irq, 1'b0);
    chk("t5_no_err", req_err, 3'b000);
    step();
    step();
    req_en = 3'b001;
    step();
    chk("t5_not_blocked", gnt, 3'b001);

    // 6: reset mid-grant
    do_reset();
    req_en = 3'b001;
    step();
    chk("t6_en_before", en, 1'b1);
    rst = 1'b1;
    #1 chk("t6_en_in_rst", en, 1'b0);
    step();
    chk("t6_gnt_rst", gnt, 3'b000);
    rst = 1'b0; req_en = 3'b011;
    step();
    chk("t6_first", gnt, 3'b001);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) req_en[i] = ~req_en[i];
      req_addr        = (7*N)'({$urandom, $urandom});
      req_wdata       = (8*N)'({$urandom, $urandom});
      req_write       = N'($urandom);
      req_multibyte_n = N'($urandom);
      rdata           = 8'($urandom);
      act             = ($urandom_range(0, 9) < 3);
      err             = ($urandom_range(0, 9) == 0);
      next            = ($urandom_range(0, 4) == 0);
      rst             = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
